// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: control-word bit positions, command metadata and
// output-side FSM encoding shared by the ALU command sequencer.
package alu_seq_pkg;

   localparam int CTRL_W = 7;

   localparam int ZX = 6;
   localparam int NX = 5;
   localparam int ZY = 4;
   localparam int NY = 3;
   localparam int F0 = 2;
   localparam int F1 = 1;
   localparam int NO = 0;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              xsel;
      logic              acc_wr;
   } cmd_meta_t;

   localparam int META_W = $bits(cmd_meta_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_e;

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational two-operand ALU with zr/ng flags.
// Signed add overflow only when ALU_SEQ_OVF_EN is defined.
module hack_alu
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [CTRL_W-1:0] ctrl,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng,
   output logic              ovf
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0] xz, xp, yz, yp, r;

   always_comb begin
      xz = ctrl[ZX] ? '0 : x;
      xp = ctrl[NX] ? ~xz : xz;
      yz = ctrl[ZY] ? '0 : y;
      yp = ctrl[NY] ? ~yz : yz;
      unique case ({ctrl[F0], ctrl[F1]})
         2'b10:   r = xp + yp;
         2'b00:   r = xp & yp;
         2'b01:   r = xp | yp;
         default: r = xp ^ yp;
      endcase
   end

   assign out = ctrl[NO] ? ~r : r;
   assign zr  = (out == '0);
   assign ng  = out[MSB];

`ifdef ALU_SEQ_OVF_EN
   // r is still the pre-negation sum when the add path is selected
   assign ovf = ctrl[F0] & ~ctrl[F1]
              & (xp[MSB] == yp[MSB])
              & (r[MSB] != xp[MSB]);
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: FIFO-buffered ALU command sequencer with accumulator.
// Define ALU_SEQ_OVF_EN to register signed add overflow on res_ovf.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CTRL_W-1:0] cmd_ctrl,
   input  logic              cmd_xsel,
   input  logic              cmd_acc_wr,
   input  logic [DATA_W-1:0] cmd_x,
   input  logic [DATA_W-1:0] cmd_y,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zr,
   output logic              res_ng,
   output logic              res_ovf,
   output logic [DATA_W-1:0] acc,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] P_ONE = AW'(1);

   typedef struct packed {
      cmd_meta_t         meta;
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            wr_entry, head;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_zr_q, res_zr_d;
   logic              res_ng_q, res_ng_d;
   logic              res_ovf_q, res_ovf_d;
   state_e            state_q, state_d;

   logic              empty, push, issue;
   logic [DATA_W-1:0] alu_x, alu_out;
   logic              alu_zr, alu_ng, alu_ovf;

   assign empty     = (count_q == '0);
   assign cmd_ready = (count_q != FULL);
   assign push      = cmd_valid & cmd_ready;
   assign res_valid = (state_q != IDLE);
   assign issue     = !empty & (!res_valid | res_ready);

   assign wr_entry = '{
      meta: '{ctrl: cmd_ctrl, xsel: cmd_xsel, acc_wr: cmd_acc_wr},
      x: cmd_x,
      y: cmd_y
   };
   assign head  = mem_q[rd_ptr_q];
   // accumulator read at issue, so back-to-back chains see fresh value
   assign alu_x = head.meta.xsel ? acc_q : head.x;

   hack_alu #(.DATA_W(DATA_W)) u_alu (
      .ctrl (head.meta.ctrl),
      .x    (alu_x),
      .y    (head.y),
      .out  (alu_out),
      .zr   (alu_zr),
      .ng   (alu_ng),
      .ovf  (alu_ovf)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      res_zr_d   = res_zr_q;
      res_ng_d   = res_ng_q;
      res_ovf_d  = res_ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + P_ONE;
      if (issue) begin
         rd_ptr_d   = rd_ptr_q + P_ONE;
         res_data_d = alu_out;
         res_zr_d   = alu_zr;
         res_ng_d   = alu_ng;
         res_ovf_d  = alu_ovf;
         if (head.meta.acc_wr) acc_d = alu_out;
      end
      case ({push, issue})
         2'b10:   count_d = count_q + C_ONE;
         2'b01:   count_d = count_q - C_ONE;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (issue) state_d = RUN;
         RUN, STALL: begin
            if (!res_ready)  state_d = STALL;
            else if (issue)  state_d = RUN;
            else             state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         acc_q      <= '0;
         res_data_q <= '0;
         res_zr_q   <= 1'b0;
         res_ng_q   <= 1'b0;
         res_ovf_q  <= 1'b0;
         state_q    <= IDLE;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         res_data_q <= res_data_d;
         res_zr_q   <= res_zr_d;
         res_ng_q   <= res_ng_d;
         res_ovf_q  <= res_ovf_d;
         state_q    <= state_d;
      end
   end

   // storage needs no reset: entries are only read below count
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign res_data = res_data_q;
   assign res_zr   = res_zr_q;
   assign res_ng   = res_ng_q;
   assign res_ovf  = res_ovf_q;
   assign acc      = acc_q;
   assign busy     = !empty | res_valid;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized and directed checks of alu_seq_ctrl
// against an in-order transaction model of the command stream.
module tb_alu_seq_ctrl;

   localparam int DW    = 16;
   localparam int DEPTH = 4;

`ifdef ALU_SEQ_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [6:0]    cmd_ctrl;
   logic          cmd_xsel, cmd_acc_wr;
   logic [DW-1:0] cmd_x, cmd_y;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_data;
   logic          res_zr, res_ng, res_ovf;
   logic [DW-1:0] acc;
   logic          busy;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ctrl   (cmd_ctrl),
      .cmd_xsel   (cmd_xsel),
      .cmd_acc_wr (cmd_acc_wr),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_zr     (res_zr),
      .res_ng     (res_ng),
      .res_ovf    (res_ovf),
      .acc        (acc),
      .busy       (busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          zr;
      logic          ng;
      logic          ovf;
      logic [DW-1:0] acc;
   } exp_t;

   exp_t          exp_q [$];
   exp_t          e_pop, e_push;
   logic [DW-1:0] m_acc;
   logic [DW-1:0] m_xin;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_pops  = 0;

   function automatic exp_t alu_ref(
      input logic [6:0]    c,
      input logic [DW-1:0] x,
      input logic [DW-1:0] y
   );
      exp_t          e;
      logic [DW-1:0] xp, yp, r;
      int            s;
      xp = c[6] ? 16'd0 : x;
      if (c[5]) xp = 16'hFFFF - xp;
      yp = c[4] ? 16'd0 : y;
      if (c[3]) yp = 16'hFFFF - yp;
      s = int'($signed(xp)) + int'($signed(yp));
      case ({c[2], c[1]})
         2'b10:   r = xp + yp;
         2'b00:   r = xp & yp;
         2'b01:   r = xp | yp;
         default: r = xp ^ yp;
      endcase
      if (c[0]) r = 16'hFFFF - r;
      e.data = r;
      e.zr   = (r == 16'd0);
      e.ng   = r[15];
      e.ovf  = OVF_ON && c[2] && !c[1]
               && (s > 32767 || s < -32768);
      e.acc  = '0;
      return e;
   endfunction

   // scoreboard: results must leave in push order with model values
   always @(negedge clk) begin
      if (!reset) begin
         if (res_valid && res_ready) begin
            n_pops++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_order: got %0h, required none", res_data);
            end else begin
               e_pop = exp_q.pop_front();
               if ({res_data, res_zr, res_ng, res_ovf, acc} !==
                   {e_pop.data, e_pop.zr, e_pop.ng, e_pop.ovf, e_pop.acc}) begin
                  n_fail++;
                  $display("FAIL sb_result: got d=%h z=%b n=%b o=%b a=%h, required d=%h z=%b n=%b o=%b a=%h",
                           res_data, res_zr, res_ng, res_ovf, acc,
                           e_pop.data, e_pop.zr, e_pop.ng, e_pop.ovf, e_pop.acc);
               end
            end
         end
         if (cmd_valid && cmd_ready) begin
            m_xin  = cmd_xsel ? m_acc : cmd_x;
            e_push = alu_ref(cmd_ctrl, m_xin, cmd_y);
            if (cmd_acc_wr) m_acc = e_push.data;
            e_push.acc = m_acc;
            exp_q.push_back(e_push);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      cmd_ctrl   = 7'($urandom);
      cmd_xsel   = 1'($urandom);
      cmd_acc_wr = 1'($urandom);
      cmd_x      = 16'($urandom);
      cmd_y      = 16'($urandom);
   endtask

   task automatic push_cmd(input logic [6:0] c, input logic xs,
                           input logic aw, input logic [DW-1:0] x,
                           input logic [DW-1:0] y);
      bit ok;
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_ctrl = c; cmd_xsel = xs; cmd_acc_wr = aw;
      cmd_x = x; cmd_y = y;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
      cmd_valid = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL push_timeout: cmd_ready=%b, required 1", cmd_ready);
      end
   endtask

   task automatic drain();
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         tick();
      end
      n_tests++;
      if (busy || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: busy=%b left=%0d, required 0 0", busy, exp_q.size());
      end
      tick();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      cmd_valid = 1'b0;
      exp_q.delete();
      m_acc = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      res_ready = 1'b1;
      rand_fields();
      apply_reset();
      @(negedge clk);
      n_tests++;
      if ({res_valid, res_data, res_zr, res_ng, res_ovf, acc, busy, cmd_ready} !==
          {1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b d=%h z=%b n=%b o=%b a=%h b=%b r=%b, required zeros with ready=1",
                  res_valid, res_data, res_zr, res_ng, res_ovf, acc, busy, cmd_ready);
      end
      tick();
   endtask

   task automatic test_latency();
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_ctrl = 7'b0000100; cmd_xsel = 1'b0; cmd_acc_wr = 1'b0;
      cmd_x = 16'd1023; cmd_y = 16'd2047;
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL lat_early: got v=%b busy=%b, required 0 1", res_valid, busy);
      end
      @(negedge clk);
      n_tests++;
      if ({res_valid, res_data, res_zr, res_ng} !== {1'b1, 16'd3070, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL lat_result: got v=%b d=%0d z=%b n=%b, required 1 3070 0 0",
                  res_valid, res_data, res_zr, res_ng);
      end
      tick();
      drain();
   endtask

   task automatic test_chain();
      int p0;
      p0 = n_pops;
      res_ready = 1'b1;
      push_cmd(7'b0000100, 1'b0, 1'b1, 16'd1023, 16'd2047);
      push_cmd(7'b0000100, 1'b1, 1'b0, 16'($urandom), 16'd1234);
      drain();
      n_tests++;
      if (acc !== 16'd3070 || n_pops != p0 + 2) begin
         n_fail++;
         $display("FAIL chain_acc: got acc=%0d pops=%0d, required 3070 2", acc, n_pops - p0);
      end
   endtask

   task automatic test_zero_neg();
      res_ready = 1'b0;
      push_cmd(7'b1010100, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      tick();
      @(negedge clk);
      n_tests++;
      if ({res_valid, res_data, res_zr, res_ng} !== {1'b1, 16'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL zero_flag: got v=%b d=%h z=%b n=%b, required 1 0000 1 0",
                  res_valid, res_data, res_zr, res_ng);
      end
      tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      push_cmd(7'b0101100, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      @(negedge clk);
      n_tests++;
      if ({res_valid, res_data, res_zr, res_ng} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL neg_flag: got v=%b d=%h z=%b n=%b, required 1 fffe 0 1",
                  res_valid, res_data, res_zr, res_ng);
      end
      tick();
      drain();
   endtask

   task automatic test_ovf();
      res_ready = 1'b0;
      push_cmd(7'b0000100, 1'b0, 1'b0, 16'd32767, 16'd1);
      tick();
      @(negedge clk);
      n_tests++;
      if ({res_data, res_ng, res_ovf} !== {16'h8000, 1'b1, OVF_ON}) begin
         n_fail++;
         $display("FAIL ovf: got d=%h n=%b o=%b, required 8000 1 %b",
                  res_data, res_ng, res_ovf, OVF_ON);
      end
      tick();
      drain();
   endtask

   task automatic test_backpressure();
      int            sent, cnt;
      logic [DW-1:0] held;
      sent = 0;
      cnt  = 0;
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      rand_fields();
      for (int i = 0; i < 12 && sent < 5; i++) begin
         @(negedge clk);
         if (cmd_ready) sent++;
         tick();
         rand_fields();
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (sent != 5 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: got sent=%0d ready=%b v=%b, required 5 0 1",
                  sent, cmd_ready, res_valid);
      end
      held = res_data;
      for (int i = 0; i < 3; i++) tick();
      @(negedge clk);
      n_tests++;
      if (res_data !== held || res_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stable: got %h v=%b, required %h 1", res_data, res_valid, held);
      end
      tick();
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (res_valid) cnt++;
         tick();
      end
      @(negedge clk);
      n_tests++;
      if (cnt != 5 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got %0d results v=%b, required 5 0", cnt, res_valid);
      end
      tick();
      drain();
   endtask

   task automatic test_back_to_back();
      int cnt, first;
      cnt   = 0;
      first = -1;
      res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cmd_valid = (i < 8);
         rand_fields();
         @(negedge clk);
         if (res_valid) begin
            cnt++;
            if (first < 0) first = i;
         end
         tick();
      end
      n_tests++;
      if (cnt != 8 || first != 2) begin
         n_fail++;
         $display("FAIL b2b: got %0d results first=%0d, required 8 2", cnt, first);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cmd_valid = ($urandom_range(3) != 0);
         res_ready = ($urandom_range(3) != 0);
         rand_fields();
         tick();
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int p0;
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push_cmd(7'($urandom), 1'($urandom), 1'b1, 16'($urandom), 16'($urandom));
      @(negedge clk);
      n_tests++;
      if ({res_valid, busy, cmd_ready} !== 3'b111) begin
         n_fail++;
         $display("FAIL mid_pre: got v=%b b=%b r=%b, required 1 1 1", res_valid, busy, cmd_ready);
      end
      tick();
      #2;
      reset = 1'b1;
      exp_q.delete();
      m_acc = '0;
      #1;
      n_tests++;
      if ({res_valid, res_data, res_zr, res_ng, res_ovf, acc, busy} !== 36'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b d=%h z=%b n=%b o=%b a=%h b=%b, required all 0",
                  res_valid, res_data, res_zr, res_ng, res_ovf, acc, busy);
      end
      tick();
      reset = 1'b0;
      res_ready = 1'b1;
      p0 = n_pops;
      push_cmd(7'b0000100, 1'b1, 1'b1, 16'($urandom), 16'd77);
      drain();
      n_tests++;
      if (n_pops != p0 + 1 || acc !== 16'd77) begin
         n_fail++;
         $display("FAIL mid_after: got pops=%0d acc=%0d, required 1 77", n_pops - p0, acc);
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      m_acc     = '0;
      rand_fields();
      test_reset();
      test_latency();
      test_chain();
      test_zero_neg();
      test_ovf();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
